fp32_pow2n_seq: RTL and testbench

//  Sequential IEEE-754 single-precision unit computing res = x^(2^n) by n repeated squarings.

---
 rtl/fp32_pow2n_seq.sv | 126 ++++++++++++
 tb/tb_fp32_pow2n_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp32_pow2n_seq.sv
// fp32_pow2n_seq: computes x^(2^n) for IEEE-754 single precision by feeding
// a one-squaring-per-cycle datapath back into itself n times.
// Squaring truncates the mantissa, always yields a positive result, and
// flushes zero/denormal operands to zero. Exponent overflow or underflow
// on any squaring, or an inf/NaN operand, ends the operation early with err.
module fp32_pow2n_seq #(
  parameter int N_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    x,
  input  logic [N_W-1:0] n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    res,
  output logic           err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         r_state;
  logic [31:0]    r_acc;
  logic [N_W-1:0] r_cnt;
  logic [31:0]    r_res;
  logic           r_err;
  logic           r_out_valid;

  logic [23:0]        w_sig;
  logic [47:0]        w_m;
  logic               w_c;
  logic [22:0]        w_mant;
  logic signed [9:0]  w_e;
  logic               w_ovf;
  logic [31:0]        w_sq;
  logic               w_unused;

  // Squaring datapath on the accumulator; the product's top bit selects
  // the normalisation shift and bumps the exponent.
  assign w_sig  = {1'b1, r_acc[22:0]};
  assign w_m    = 48'(w_sig) * 48'(w_sig);
  assign w_c    = w_m[47];
  assign w_mant = w_c ? w_m[46:24] : w_m[45:23];
  assign w_e    = $signed({1'b0, r_acc[30:23], 1'b0}) - 10'sd127
                + $signed({9'd0, w_c});
  assign w_ovf  = (w_e > 10'sd254) || (w_e < 10'sd1);
  assign w_sq   = {1'b0, w_e[7:0], w_mant};

  // Truncated product bits and the accumulator sign never reach a result.
  assign w_unused = ^{w_m[22:0], r_acc[31]};

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign err       = r_err;

  // Control FSM: accept in IDLE, square once per cycle in CALC, hold the
  // result in DONE until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (n == '0) begin
              // Zero squarings: pass the operand through untouched.
              r_res       <= x;
              r_err       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (x[30:23] == 8'd0) begin
              r_res       <= '0;
              r_err       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (x[30:23] == 8'hFF) begin
              r_res       <= '0;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_acc   <= x;
              r_cnt   <= n;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (w_ovf) begin
            r_res       <= '0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_acc <= w_sq;
            r_cnt <= r_cnt - N_W'(1);
            // Exit on the last squaring so the counter never wraps.
            if (r_cnt == N_W'(1)) begin
              r_res       <= w_sq;
              r_err       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_pow2n_seq.sv
// Directed bench for fp32_pow2n_seq: a vector table of hand-computed
// results and latencies, plus backpressure and mid-operation reset sequences.
module tb_fp32_pow2n_seq;

  localparam int N_W = 5;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    x;
  logic [N_W-1:0] n;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    res;
  logic           err;
  logic           busy;

  int n_pass;
  int n_total;

  fp32_pow2n_seq #(.N_W(N_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .n(n), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]    x;
    logic [N_W-1:0] n;
    logic [31:0]    res;
    logic           err;
    int             lat;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one operation, measure cycles to out_valid, check result, then
  // let it drain with out_ready high.
  task automatic run_op(input int idx, input logic [31:0] vx, input logic [N_W-1:0] vn,
                        input logic [31:0] eres, input logic eerr, input int elat);
    int cyc;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    x = vx;
    n = vn;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 32'hDEADBEEF;
    n = '1;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " latency"}, cyc, elat);
    chk({tag, " res"}, res, eres);
    chk({tag, " err"}, {31'd0, err}, {31'd0, eerr});
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " drained"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    n_pass = 0;
    n_total = 0;

    vecs[0]  = '{32'h40000000, 5'd1,  32'h40800000, 1'b0, 1};
    vecs[1]  = '{32'h40000000, 5'd2,  32'h41800000, 1'b0, 2};
    vecs[2]  = '{32'h3FC00000, 5'd1,  32'h40100000, 1'b0, 1};
    vecs[3]  = '{32'hC0400000, 5'd1,  32'h41100000, 1'b0, 1};
    vecs[4]  = '{32'h71800000, 5'd5,  32'h00000000, 1'b1, 1};
    vecs[5]  = '{32'h0D800000, 5'd1,  32'h00000000, 1'b1, 1};
    vecs[6]  = '{32'h00000000, 5'd3,  32'h00000000, 1'b0, 0};
    vecs[7]  = '{32'h7F800000, 5'd1,  32'h00000000, 1'b1, 0};
    vecs[8]  = '{32'hC0400000, 5'd0,  32'hC0400000, 1'b0, 0};
    vecs[9]  = '{32'h3F800000, 5'd31, 32'h3F800000, 1'b0, 31};
    vecs[10] = '{32'h5F000000, 5'd1,  32'h7E800000, 1'b0, 1};  // 2^63 -> 2^126
    vecs[11] = '{32'h5F800000, 5'd1,  32'h00000000, 1'b1, 1};  // 2^64 -> overflow
    vecs[12] = '{32'h20000000, 5'd1,  32'h00800000, 1'b0, 1};  // 2^-63 -> 2^-126
    vecs[13] = '{32'h1F800000, 5'd1,  32'h00000000, 1'b1, 1};  // 2^-64 -> underflow
    vecs[14] = '{32'h3FFFFFFF, 5'd1,  32'h407FFFFE, 1'b0, 1};  // truncation
    vecs[15] = '{32'h7FC00000, 5'd2,  32'h00000000, 1'b1, 0};
    vecs[16] = '{32'h00000001, 5'd2,  32'h00000000, 1'b0, 0};
    vecs[17] = '{32'h80000000, 5'd1,  32'h00000000, 1'b0, 0};
    vecs[18] = '{32'h7F800000, 5'd0,  32'h7F800000, 1'b0, 0};
    vecs[19] = '{32'h40000000, 5'd6,  32'h5F800000, 1'b0, 6};
    vecs[20] = '{32'h40000000, 5'd7,  32'h00000000, 1'b1, 7};  // early exit
    vecs[21] = '{32'hC0000000, 5'd2,  32'h41800000, 1'b0, 2};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    n = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset res", res, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) run_op(i, vecs[i].x, vecs[i].n, vecs[i].res, vecs[i].err, vecs[i].lat);

    // Backpressure: result held in DONE, new requests ignored.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    x = 32'h40000000;
    n = 5'd1;
    @(posedge clk);
    #1;
    x = 32'h3FC00000;  // in_valid stays high; must not be taken while busy
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp latency", cyc, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp hold%0d valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp hold%0d res", k), res, 32'h40800000);
      chk($sformatf("bp hold%0d err", k), {31'd0, err}, 32'd0);
      chk($sformatf("bp hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp release valid", {31'd0, out_valid}, 32'd0);
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp release res kept", res, 32'h40800000);
    @(posedge clk);
    #1;
    chk("bp no accept busy", {31'd0, busy}, 32'd0);

    // Reset pulse in the middle of a long operation.
    @(negedge clk);
    in_valid = 1'b1;
    x = 32'h40000000;
    n = 5'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid busy before rst", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst res", res, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst release in_ready", {31'd0, in_ready}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst op dropped", {30'd0, out_valid, busy}, 32'd0);

    // Normal operation still works after the reset.
    run_op(99, 32'h3FC00000, 5'd1, 32'h40100000, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
